// File: rtl/lamp_seq_pkg.sv
// lamp_seq_pkg: shared types, width helpers and default segment table for the lamp sequencer.
package lamp_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int lw_of(input int mx_lp);
        return $clog2(mx_lp + 1);
    endfunction

    function automatic int saw_of(input int nseg);
        return (nseg > 1) ? $clog2(nseg) : 1;
    endfunction

    localparam int DEF_T0 = 16;
    localparam int DEF_T1 = 5;
    localparam int DEF_T2 = 10;
    localparam int DEF_T3 = 0;

    function automatic int def_tgt(input int i);
        return (i == 0) ? DEF_T0 : (i == 1) ? DEF_T1 : (i == 2) ? DEF_T2 : DEF_T3;
    endfunction

    // Any target above the lamp count marks the end of the sequence.
    function automatic logic is_end(input int target, input int mx_lp);
        return target > mx_lp;
    endfunction

endpackage

// File: rtl/lamp_seq_ctl_tick.sv
// lamp_tick_gen: step-tick prescaler, counts 0..TICK_DIV-1 while enabled and holds 0 otherwise.
module lamp_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

    always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/lamp_seq_ctl.sv
// lamp_seq_ctl: segment-table sequencer emitting go_up/go_dwn lamp steps on prescaled ticks.
// Define LAMP_SEQ_LOOP_EN to restart the table from segment 0 at END instead of finishing.
module lamp_seq_ctl
    import lamp_seq_pkg::*;
#(
    parameter int MX_LP    = 16,
    parameter int NSEG     = 4,
    parameter int TICK_DIV = 1,
    parameter int LW       = lw_of(MX_LP),
    parameter int SAW      = saw_of(NSEG)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic           flick,
    input  logic           cfg_wr,
    input  logic [SAW-1:0] cfg_addr,
    input  logic [LW-1:0]  cfg_data,
    output logic           go_up,
    output logic           go_dwn,
    output logic [LW-1:0]  level,
    output logic [SAW-1:0] seg_idx,
    output logic           busy,
    output logic           done,
    output logic           cfg_err
);

    state_t         state_q, state_d;
    logic [LW-1:0]  tgt_q [NSEG];
    logic [LW-1:0]  tgt_d [NSEG];
    logic [LW-1:0]  level_q, level_d;
    logic [SAW-1:0] seg_idx_q, seg_idx_d;
    logic           dir_dn_q, dir_dn_d;
    logic           go_up_q, go_up_d;
    logic           go_dwn_q, go_dwn_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           cfg_err_q, cfg_err_d;
    logic           tick;
    logic           seg_end;
    logic [LW-1:0]  tgt;

    lamp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy_q),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        level_d   = level_q;
        seg_idx_d = seg_idx_q;
        dir_dn_d  = dir_dn_q;
        go_up_d   = 1'b0;
        go_dwn_d  = 1'b0;
        done_d    = 1'b0;
        cfg_err_d = cfg_wr && (state_q != IDLE);
        seg_end   = 1'b0;
        tgt       = tgt_q[seg_idx_q];
        case (state_q)
            IDLE: begin
                if (cfg_wr) tgt_d[cfg_addr] = cfg_data;
                if (start) begin
                    state_d   = RUN;
                    seg_idx_d = '0;
                    dir_dn_d  = 1'b0;
                end
            end
            RUN: begin
                if (stop) state_d = DRAIN;
                else if (tick) begin
                    if (is_end(int'(tgt), MX_LP)) seg_end = 1'b1;
                    else if (level_q < tgt) begin
                        if (level_q < LW'(MX_LP)) begin
                            go_up_d = 1'b1;
                            level_d = level_q + 1'b1;
                        end
                        dir_dn_d = 1'b0;
                    end else if (level_q > tgt) begin
                        go_dwn_d = 1'b1;
                        level_d  = level_q - 1'b1;
                        dir_dn_d = 1'b1;
                    end else if (dir_dn_q && flick && seg_idx_q != '0) seg_idx_d = seg_idx_q - 1'b1;
                    else if (seg_idx_q == SAW'(NSEG - 1)) seg_end = 1'b1;
                    else seg_idx_d = seg_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                if (tick) begin
                    if (level_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        go_dwn_d = 1'b1;
                        level_d  = level_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (seg_end) begin
`ifdef LAMP_SEQ_LOOP_EN
            seg_idx_d = '0;
`else
            state_d = (level_q == '0) ? IDLE : DRAIN;
            done_d  = (level_q == '0);
`endif
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < NSEG; i++) tgt_q[i] <= LW'(def_tgt(i));
            level_q   <= '0;
            seg_idx_q <= '0;
            dir_dn_q  <= 1'b0;
            go_up_q   <= 1'b0;
            go_dwn_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            level_q   <= level_d;
            seg_idx_q <= seg_idx_d;
            dir_dn_q  <= dir_dn_d;
            go_up_q   <= go_up_d;
            go_dwn_q  <= go_dwn_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign go_up   = go_up_q;
    assign go_dwn  = go_dwn_q;
    assign level   = level_q;
    assign seg_idx = seg_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lamp_seq_ctl.sv
// tb_lamp_seq_ctl: scoreboard bench; expected pulse events are queued by stimulus and popped by monitors.
module tb_lamp_seq_ctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, flick = 1'b0, cfg_wr = 1'b0, start3 = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [4:0] cfg_data = '0;
    logic go_up, go_dwn, busy, done, cfg_err;
    logic [4:0] level;
    logic [1:0] seg_idx;
    logic go_up3, go_dwn3, busy3, done3, cfg_err3;
    logic [4:0] level3;
    logic [1:0] seg_idx3;

    always #5 clk = ~clk;

    lamp_seq_ctl #(.TICK_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .flick(flick),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .go_up(go_up), .go_dwn(go_dwn), .level(level), .seg_idx(seg_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    lamp_seq_ctl #(.TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stop(1'b0), .flick(1'b0),
        .cfg_wr(1'b0), .cfg_addr(2'b00), .cfg_data(5'd0),
        .go_up(go_up3), .go_dwn(go_dwn3), .level(level3), .seg_idx(seg_idx3),
        .busy(busy3), .done(done3), .cfg_err(cfg_err3)
    );

    typedef struct {
        logic [2:0] p;
        int lvl;
        int seg;
        int off;
    } ev_t;

    ev_t q1[$];
    ev_t q3[$];
    int  cyc = 0, s3 = 0, k3 = 0;
    int  checks = 0, errors = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit d3, input logic [2:0] p, input int lvl, input int seg);
        ev_t e;
        e.p = p; e.lvl = lvl; e.seg = seg; e.off = 3 * k3 + 1;
        if (d3) q3.push_back(e);
        else    q1.push_back(e);
    endtask

    task automatic ramp(input bit d3, input int from, input int to, input int seg);
        int l = from;
        while (l != to) begin
            l += (to > from) ? 1 : -1;
            k3++;
            push(d3, (to > from) ? 3'b100 : 3'b010, l, seg);
        end
    endtask

    task automatic push_default(input bit d3);
        k3 = 0;
        ramp(d3, 0, 16, 0);  k3++;
        ramp(d3, 16, 5, 1);  k3++;
        ramp(d3, 5, 10, 2);  k3++;
        ramp(d3, 10, 0, 3);  k3++;
        push(d3, 3'b001, 0, 3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input bit d3, input int maxc);
        int n = 0;
        while ((d3 ? busy3 : busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("busy_timeout", 32'(d3 ? busy3 : busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("pending_events", 32'(d3 ? q3.size() : q1.size()), 32'd0);
    endtask

    task automatic wait_seg(input int s, input int maxc);
        int n = 0;
        while (seg_idx != 2'(s) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("seg_timeout", 32'(seg_idx), 32'(s));
    endtask

    task automatic wait_lvl(input int v, input int maxc);
        int n = 0;
        while (level != 5'(v) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("level_timeout", 32'(level), 32'(v));
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (go_up | go_dwn | done) begin
                if (q1.size() == 0) chk("unexpected_pulse", 32'({go_up, go_dwn, done}), 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("pulse_kind", 32'({go_up, go_dwn, done}), 32'(e.p));
                    chk("pulse_level", 32'(level), 32'(e.lvl));
                    chk("pulse_seg", 32'(seg_idx), 32'(e.seg));
                end
            end
        end
    end

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (go_up3 | go_dwn3 | done3) begin
                if (q3.size() == 0) chk("t3_unexpected_pulse", 32'({go_up3, go_dwn3, done3}), 32'd0);
                else begin
                    e = q3.pop_front();
                    chk("t3_pulse_kind", 32'({go_up3, go_dwn3, done3}), 32'(e.p));
                    chk("t3_level", 32'(level3), 32'(e.lvl));
                    chk("t3_seg", 32'(seg_idx3), 32'(e.seg));
                    chk("t3_cycle_offset", 32'(cyc - s3), 32'(e.off));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({go_up, go_dwn, level, seg_idx, busy, done, cfg_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // TICK_DIV=3: first step 4 cycles after start, steps 3 apart, gaps on equal-target ticks
        push_default(1'b1);
        s3 = cyc;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        wait_done(1'b1, 400);

        // default table, single pass
        push_default(1'b0);
        pulse_start();
        wait_done(1'b0, 200);

        // flick kickback at level 5 returns to segment 0
        k3 = 0;
        ramp(1'b0, 0, 16, 0);
        ramp(1'b0, 16, 5, 1);
        ramp(1'b0, 5, 16, 0);
        ramp(1'b0, 16, 5, 1);
        ramp(1'b0, 5, 10, 2);
        ramp(1'b0, 10, 0, 3);
        push(1'b0, 3'b001, 0, 3);
        flick = 1'b1;
        pulse_start();
        wait_seg(1, 100);
        wait_seg(0, 100);
        flick = 1'b0;
        wait_done(1'b0, 300);

        // END written with start, then a rejected write while running
        ramp(1'b0, 0, 16, 0);
        ramp(1'b0, 16, 5, 1);
        ramp(1'b0, 5, 0, 2);
        push(1'b0, 3'b001, 0, 2);
        cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_data = 5'd31;
        pulse_start();
        cfg_wr = 1'b0;
        chk("cfg_err_idle_write", 32'(cfg_err), 32'd0);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_data = 5'd7;
        @(negedge clk);
        cfg_wr = 1'b0;
        chk("cfg_err_busy_write", 32'(cfg_err), 32'd1);
        @(negedge clk);
        chk("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
        wait_done(1'b0, 200);

        // stop at level 9 drains; start during drain ignored
        ramp(1'b0, 0, 9, 0);
        ramp(1'b0, 9, 0, 0);
        push(1'b0, 3'b001, 0, 0);
        pulse_start();
        wait_lvl(9, 50);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("busy_in_drain", 32'(busy), 32'd1);
        @(negedge clk);
        pulse_start();
        wait_done(1'b0, 100);

        // asynchronous reset mid-run at level 7
        ramp(1'b0, 0, 7, 0);
        pulse_start();
        wait_lvl(7, 50);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'({go_up, go_dwn, level, seg_idx, busy, done, cfg_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("pending_after_reset", 32'(q1.size()), 32'd0);

        // table restored to defaults by reset
        push_default(1'b0);
        pulse_start();
        wait_done(1'b0, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
